// File: rtl/rgb_fade_sequencer.sv
// RGB LED palette sequencer: walks a 7-colour rainbow and crossfades the three
// PWM duty words linearly toward each new colour, on request or after a hold time.
module rgb_fade_sequencer #(
    parameter int TICK_DIV   = 1_000_000,
    parameter int HOLD_TICKS = 100,
    parameter int STEP       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       auto,
    input  logic       dir,
    input  logic       step_req,
    output logic [7:0] duty_r,
    output logic [7:0] duty_g,
    output logic [7:0] duty_b,
    output logic [2:0] color_idx,
    output logic       busy
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS - 1);
    localparam logic [7:0]    STEP8     = 8'(STEP);

    typedef enum logic {SETTLED, FADE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [2:0]    idx_q, idx_d;
    logic          pend_q, pend_d;
    logic [23:0]   duty_q, duty_d;
    logic [23:0]   target;
    wire  [23:0]   stepped;
    logic          tick;
    logic          auto_fire;
    logic          fade_done;

    function automatic logic [23:0] palette(input logic [2:0] i);
        case (i)
            3'd0:    return 24'h7F_00_00;
            3'd1:    return 24'h7F_52_00;
            3'd2:    return 24'h7F_7F_00;
            3'd3:    return 24'h00_7F_00;
            3'd4:    return 24'h00_00_7F;
            3'd5:    return 24'h25_00_41;
            3'd6:    return 24'h77_41_77;
            default: return 24'h7F_00_00;
        endcase
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] i, input logic d);
        if (d)
            return (i == 3'd0) ? 3'd6 : i - 3'd1;
        return (i == 3'd6) ? 3'd0 : i + 3'd1;
    endfunction

    assign target = palette(idx_q);

    // Each channel moves by at most STEP and lands exactly on target, so no overshoot or wrap.
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [7:0] cur, tgt, diff;
        assign cur  = duty_q[gi*8 +: 8];
        assign tgt  = target[gi*8 +: 8];
        assign diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        assign stepped[gi*8 +: 8] = (diff > STEP8) ?
                                    ((tgt >= cur) ? (cur + STEP8) : (cur - STEP8)) : tgt;
    end

    assign fade_done = (stepped == target);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        duty_d    = duty_q;
        tick      = 1'b0;
        auto_fire = 1'b0;
        if (en) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end

            if (state_q == SETTLED) begin
                auto_fire = auto && tick && (hold_q == HOLD_MAX);
                if (!auto)
                    hold_d = '0;
                else if (tick)
                    hold_d = (hold_q == HOLD_MAX) ? '0 : hold_q + 1'b1;
                // A manual request coinciding with the auto tick still yields one advance.
                if (step_req || auto_fire) begin
                    idx_d   = next_idx(idx_q, dir);
                    state_d = FADE;
                    hold_d  = '0;
                end
            end else begin
                if (step_req)
                    pend_d = 1'b1;
                if (tick) begin
                    duty_d = stepped;
                    if (fade_done) begin
                        hold_d = '0;
                        if (pend_q || step_req) begin
                            idx_d  = next_idx(idx_q, dir);
                            pend_d = 1'b0;
                        end else begin
                            state_d = SETTLED;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SETTLED;
            presc_q <= '0;
            hold_q  <= '0;
            idx_q   <= 3'd0;
            pend_q  <= 1'b0;
            duty_q  <= 24'h7F_00_00;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            duty_q  <= duty_d;
        end
    end

    assign duty_r    = duty_q[23:16];
    assign duty_g    = duty_q[15:8];
    assign duty_b    = duty_q[7:0];
    assign color_idx = idx_q;
    assign busy      = (state_q == FADE);

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer: unit A at STEP=1, unit B at STEP=16,
// both with TICK_DIV=4 and HOLD_TICKS=3.
module tb_rgb_fade_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b1, auto = 1'b0, dir = 1'b0, step_req = 1'b0;
    logic       b_dir = 1'b0, b_step = 1'b0;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic [2:0] a_idx, b_idx;
    logic       a_busy, b_busy;

    logic        sel = 1'b0;
    logic [23:0] cur_rgb;
    logic [2:0]  cur_idx;
    logic        cur_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_fade_sequencer #(.TICK_DIV(4), .HOLD_TICKS(3), .STEP(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .auto(auto), .dir(dir), .step_req(step_req),
        .duty_r(a_r), .duty_g(a_g), .duty_b(a_b), .color_idx(a_idx), .busy(a_busy)
    );

    rgb_fade_sequencer #(.TICK_DIV(4), .HOLD_TICKS(3), .STEP(16)) u_b (
        .clk(clk), .rst(rst), .en(en), .auto(1'b0), .dir(b_dir), .step_req(b_step),
        .duty_r(b_r), .duty_g(b_g), .duty_b(b_b), .color_idx(b_idx), .busy(b_busy)
    );

    always_comb begin
        cur_rgb  = sel ? {b_r, b_g, b_b} : {a_r, a_g, a_b};
        cur_idx  = sel ? b_idx : a_idx;
        cur_busy = sel ? b_busy : a_busy;
    end

    typedef struct {
        logic        dir;
        logic [2:0]  idx;
        logic [23:0] rgb;
        int          ticks;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s);
        if (s) b_step = 1'b1; else step_req = 1'b1;
        @(negedge clk);
        b_step   = 1'b0;
        step_req = 1'b0;
    endtask

    task automatic wait_change(input int budget, output int n);
        logic [23:0] prev;
        prev = cur_rgb;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cur_rgb == prev && n < budget);
        chk("tick_seen", int'(cur_rgb != prev), 1);
    endtask

    task automatic run_fade(input int budget, output int ticks, output int cycles);
        logic [23:0] prev;
        prev   = cur_rgb;
        ticks  = 0;
        cycles = 0;
        while (cur_busy && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (cur_rgb != prev) ticks++;
            prev = cur_rgb;
        end
        chk("fade_ends", int'(cur_busy), 0);
    endtask

    initial begin
        int  n, t, c, g0;
        bit  gap, moved;
        logic [23:0] rgb0;

        vecs[0] = '{1'b1, 3'd5, 24'h25_00_41, 6};
        vecs[1] = '{1'b0, 3'd6, 24'h77_41_77, 6};
        vecs[2] = '{1'b0, 3'd0, 24'h7F_00_00, 8};
        vecs[3] = '{1'b0, 3'd1, 24'h7F_52_00, 6};
        vecs[4] = '{1'b0, 3'd2, 24'h7F_7F_00, 3};
        vecs[5] = '{1'b0, 3'd3, 24'h00_7F_00, 8};
        vecs[6] = '{1'b0, 3'd4, 24'h00_00_7F, 8};
        vecs[7] = '{1'b0, 3'd5, 24'h25_00_41, 4};
        vecs[8] = '{1'b1, 3'd4, 24'h00_00_7F, 4};

        // Reset and idle stability
        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rgb", int'(cur_rgb), 24'h7F0000);
        chk("rst_idx", int'(cur_idx), 0);
        chk("rst_busy", int'(cur_busy), 0);
        cyc(20);
        chk("idle_rgb", int'(cur_rgb), 24'h7F0000);
        chk("idle_busy", int'(cur_busy), 0);

        // Forward manual step at STEP=1
        pulse(1'b0);
        chk("fwd_idx", int'(a_idx), 1);
        chk("fwd_busy", int'(a_busy), 1);
        run_fade(400, t, c);
        chk("fwd_ticks", t, 82);
        chk("fwd_dur", int'(c >= 325 && c <= 328), 1);
        chk("fwd_rgb", int'(cur_rgb), 24'h7F5200);

        // Backward wrap with clamping at STEP=16
        sel   = 1'b1;
        b_dir = 1'b1;
        pulse(1'b1);
        chk("wrap_idx", int'(b_idx), 6);
        chk("wrap_busy", int'(b_busy), 1);
        for (int k = 0; k < 8; k++) begin
            int ge, be;
            wait_change(8, n);
            ge = (16 * (k + 1) < 'h41) ? 16 * (k + 1) : 'h41;
            be = (16 * (k + 1) < 'h77) ? 16 * (k + 1) : 'h77;
            chk($sformatf("wrap_t%0d_rgb", k + 1), int'(cur_rgb), (32'h77 << 16) | (ge << 8) | be);
            chk($sformatf("wrap_t%0d_busy", k + 1), int'(cur_busy), (k < 7) ? 1 : 0);
        end

        for (int v = 0; v < 9; v++) begin
            b_dir = vecs[v].dir;
            pulse(1'b1);
            chk($sformatf("vec%0d_idx", v), int'(b_idx), int'(vecs[v].idx));
            run_fade(200, t, c);
            chk($sformatf("vec%0d_ticks", v), t, vecs[v].ticks);
            chk($sformatf("vec%0d_rgb", v), int'(cur_rgb), int'(vecs[v].rgb));
        end
        sel   = 1'b0;
        b_dir = 1'b0;

        // Queued requests: three extra pulses give exactly one more advance
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_rgb", int'(cur_rgb), 24'h7F0000);
        pulse(1'b0);
        chk("q_idx1", int'(a_idx), 1);
        for (int k = 0; k < 3; k++) begin
            cyc(20);
            pulse(1'b0);
        end
        gap = 1'b0;
        n   = 0;
        while (a_idx == 3'd1 && n < 400) begin
            @(negedge clk);
            n++;
            if (!a_busy) gap = 1'b1;
        end
        chk("q_idx2", int'(a_idx), 2);
        chk("q_nogap", int'(gap), 0);
        chk("q_g_final", int'(a_g), 'h52);
        run_fade(300, t, c);
        chk("q_ticks", t, 45);
        chk("q_rgb", int'(cur_rgb), 24'h7F7F00);
        cyc(30);
        chk("q_idx_end", int'(a_idx), 2);
        chk("q_busy_end", int'(a_busy), 0);

        // Auto mode from idx 6
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        dir = 1'b1;
        @(negedge clk);
        pulse(1'b0);
        chk("bk_idx", int'(a_idx), 6);
        run_fade(600, t, c);
        chk("bk_ticks", t, 119);
        chk("bk_rgb", int'(cur_rgb), 24'h774177);
        dir  = 1'b0;
        auto = 1'b1;
        n    = 0;
        gap  = 1'b0;
        while (a_idx == 3'd6 && n < 40) begin
            @(negedge clk);
            n++;
            if (a_idx == 3'd6 && a_busy) gap = 1'b1;
        end
        chk("auto_hold1", n, 12);
        chk("auto_idle_in_hold", int'(gap), 0);
        chk("auto_idx0", int'(a_idx), 0);
        run_fade(600, t, c);
        chk("auto_ticks", t, 119);
        chk("auto_rgb", int'(cur_rgb), 24'h7F0000);
        // Manual request on the same edge as the auto advance
        n = 0;
        while (a_idx == 3'd0 && n < 40) begin
            if (n == 11) step_req = 1'b1;
            @(negedge clk);
            step_req = 1'b0;
            n++;
        end
        auto = 1'b0;
        chk("auto_hold2", n, 12);
        chk("auto_idx1", int'(a_idx), 1);

        // Freeze mid-fade
        wait_change(8, n);
        wait_change(8, n);
        rgb0  = cur_rgb;
        g0    = int'(a_g);
        en    = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step_req = (i % 10 == 3);
            @(negedge clk);
            if (cur_rgb != rgb0 || !a_busy) moved = 1'b1;
        end
        step_req = 1'b0;
        chk("frz_hold", int'(moved), 0);
        en = 1'b1;
        wait_change(10, n);
        chk("frz_presc", n, 4);
        run_fade(400, t, c);
        chk("frz_remaining", t + 1, 'h52 - g0);
        cyc(20);
        chk("frz_idx", int'(a_idx), 1);
        chk("frz_nopend", int'(a_busy), 0);

        // Reset mid-fade with a pending request
        pulse(1'b0);
        wait_change(8, n);
        pulse(1'b0);
        cyc(3);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_rgb", int'(cur_rgb), 24'h7F0000);
        chk("mrst_idx", int'(a_idx), 0);
        chk("mrst_busy", int'(a_busy), 0);
        rst = 1'b0;
        cyc(10);
        pulse(1'b0);
        run_fade(400, t, c);
        cyc(10);
        chk("mrst_pend_clr", int'(a_idx), 1);
        chk("mrst_busy_end", int'(a_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_fade_sequencer.md
# rgb_fade_sequencer

Palette controller for the on-board RGB LED. It owns the 7-colour rainbow palette and the colour index, and generates the three 8-bit duty-cycle words that feed the existing per-channel `pwm` instances. Unlike a direct colour switch, it crossfades linearly from the current colour to the next one. It advances on manual step requests (already debounced and edge-detected upstream) or automatically after a programmable hold time.

## Interface
- `TICK_DIV`, 1_000_000: clk cycles per fade tick (100 Hz at 100 MHz); legal range ≥2.
- `HOLD_TICKS`, 100: ticks spent at a settled colour before an auto-advance; legal range ≥1.
- `STEP`, 1: maximum duty change per channel per tick; legal range 1..127.

- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: global enable; 0 freezes all state.
- `auto` in 1: 1 enables timed auto-advance.
- `dir` in 1: direction, sampled at advance; 0 = forward (red→violet), 1 = backward.
- `step_req` in 1: single-cycle advance request pulse.
- `duty_r`, `duty_g`, `duty_b` out 8 each: registered duty words to the PWM channels.
- `color_idx` out 3: current target colour index, 0..6.
- `busy` out 1: 1 while a fade is in progress.

## Operation
- Palette, as {R,G,B} hex:
  - 0 red 7F,00,00
  - 1 orange 7F,52,00
  - 2 yellow 7F,7F,00
  - 3 green 00,7F,00
  - 4 blue 00,00,7F
  - 5 indigo 25,00,41
  - 6 violet 77,41,77
- Index arithmetic wraps in both directions: 6+1→0 and 0−1→6. Values 7 are never produced.
- Prescaler: counts 0..TICK_DIV−1 while `en`=1. `tick` is asserted for one cycle when the count equals TICK_DIV−1, and the count then returns to 0.
- State machine: SETTLED and FADE.
  - **SETTLED:**
    - `step_req`=1 triggers an advance.
    - Otherwise, when `auto`=1, `hold_cnt` increments on each tick. On the tick where `hold_cnt`=HOLD_TICKS−1, an advance occurs and `hold_cnt` is cleared.
    - `auto`=0 holds `hold_cnt` at 0.
  - **Advance:** `color_idx` ← next(`color_idx`, `dir`); state ← FADE.
  - **FADE:** on each tick, each channel moves toward `palette[color_idx]` by min(STEP, |target−duty|). Arithmetic is 8-bit unsigned and can never overshoot or wrap. On the tick where all three channels become equal to the target, state ← SETTLED and `hold_cnt` ← 0.
- Pending request:
  - A `step_req` during FADE sets a 1-deep `pending` flag. Further requests are dropped.
  - On fade completion with `pending`=1, the block advances immediately (no hold) and clears `pending`.
- `en`=0: prescaler, `hold_cnt`, FSM, duties and `pending` are all frozen. `step_req` is ignored (not latched).
- `dir` and `auto` changes take effect only at the next advance decision. A fade in progress always completes toward its latched target.

## Timing
- Reset values: `duty_r`/`g`/`b` = 7F/00/00, `color_idx` = 0, `busy` = 0, state SETTLED, prescaler 0, `hold_cnt` 0, `pending` 0.
- Reset mid-fade returns all of the above in the cycle after `rst` is sampled high.
- `step_req` in SETTLED at cycle n: `color_idx` and `busy`=1 become visible at n+1.
- Duties change only on tick cycles and are visible the cycle after the tick.
- `busy` falls on the same edge that writes the final duty value.
- Pending advance on completion: `color_idx` updates on that same edge, and `busy` stays 1 with no gap.
- Fade duration is ceil(max channel |Δ| / STEP) ticks; worst case 127 ticks (e.g. red→green at STEP=1).
- `step_req` coincident with an auto-advance tick produces exactly one advance.

## Test plan
Bench parameters: TICK_DIV=4, HOLD_TICKS=3.

1. **Reset:** hold `rst`=1 for 2 cycles → duties 7F/00/00, `color_idx`=0, `busy`=0; outputs are stable thereafter with `en`=1, `auto`=0.
2. **Forward manual step** (STEP=1, `dir`=0): pulse `step_req` → next cycle `color_idx`=1, `busy`=1. `duty_g` +1 per 4 clks, reaching 0x52 after 82 ticks (328 clks); then `busy`=0, R=7F, B=00.
3. **Backward wrap with clamping** (STEP=16, `dir`=1, from idx 0): `color_idx`=6.
   - R: 7F→77 in 1 tick.
   - G: 10,20,30,40,41.
   - B: 10..70,77.
   - `busy` falls after 8 ticks.
4. **Queued requests:** three `step_req` pulses during the fade from 0→1 → exactly one extra advance. `color_idx`=2 on the completion edge, `busy` has no low cycle, final idx=2.
5. **Auto mode:** `auto`=1 starting at settled idx 6, `dir`=0 → advance after 3 ticks (12 clks) to idx 0, fade to 7F/00/00, hold 3 ticks, then advance to idx 1.
6. **Freeze and reset:**
   - Mid-fade, `en`=0 for 50 cycles while pulsing `step_req` → duties, prescaler and `pending` are unchanged; after `en`=1, the fade resumes with the same remaining tick count.
   - Then assert `rst` mid-fade → 7F/00/00, idx 0, `busy` 0, `pending` 0 next cycle.
